// File: rtl/sass_beat_pkg.sv
// Shared types and constants for the beat interface: beat index, tempo index
// and the beat generator state, plus the saturating tempo step rule.
package sass_beat_pkg;

   typedef logic [2:0] beat_t;
   typedef logic [2:0] tempo_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } beat_state_t;

   localparam int NUM_BEATS     = 8;
   localparam int MAX_TEMPO_IDX = 7;

   // Simultaneous up and down pulses cancel; otherwise step and clamp to 0..7.
   function automatic tempo_idx_t next_tempo(input tempo_idx_t idx,
                                             input logic       up,
                                             input logic       down);
      tempo_idx_t res;
      res = idx;
      if (up && !down && (int'(idx) < MAX_TEMPO_IDX))
         res = idx + tempo_idx_t'(1);
      else if (down && !up && (idx != '0))
         res = idx - tempo_idx_t'(1);
      return res;
   endfunction

endpackage

// File: rtl/beat_sync_gen_tempo_ctrl.sv
// Tempo index register with saturating up/down control, and the matching
// registered "last counter value of a beat" (period - 1) for that index.
module tempo_ctrl
   import sass_beat_pkg::*;
#(
   parameter int MAX_PERIOD    = 1_500_000,
   parameter int STEP_PERIOD   = 150_000,
   parameter int DEFAULT_TEMPO = 3,
   parameter int CNT_W         = $clog2(MAX_PERIOD)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tempo_up,
   input  logic             tempo_down,
   output tempo_idx_t       tempo_idx,
   output logic [CNT_W-1:0] period_last
);

   localparam logic [CNT_W-1:0] LAST_MAX = CNT_W'(MAX_PERIOD - 1);
   localparam logic [CNT_W-1:0] STEP     = CNT_W'(STEP_PERIOD);

   tempo_idx_t idx_next;

   // period - 1 fits the counter width even at tempo 0, where period itself
   // may need one more bit than the counter has.
   function automatic logic [CNT_W-1:0] last_for(input tempo_idx_t idx);
      return LAST_MAX - (CNT_W'(idx) * STEP);
   endfunction

   always_comb idx_next = next_tempo(tempo_idx, tempo_up, tempo_down);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, regardless of the order the simulator runs blocks in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tempo_idx   <= tempo_idx_t'(DEFAULT_TEMPO);
         period_last <= last_for(tempo_idx_t'(DEFAULT_TEMPO));
      end else begin
         tempo_idx   <= idx_next;
         period_last <= last_for(idx_next);
      end
   end

endmodule

// File: rtl/beat_sync_gen.sv
// Beat source for the sequencer: 8-beat bar counter with beat/bar strobes,
// pause and start/stop control; the tempo is owned by tempo_ctrl.
module beat_sync_gen
   import sass_beat_pkg::*;
#(
   parameter int MAX_PERIOD    = 1_500_000,
   parameter int STEP_PERIOD   = 150_000,
   parameter int DEFAULT_TEMPO = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sequencer_on,
   input  logic       pause,
   input  logic       tempo_up,
   input  logic       tempo_down,
   output logic [2:0] beat,
   output logic       beat_strobe,
   output logic       bar_strobe,
   output logic [2:0] tempo_idx
);

   localparam int    CNT_W     = $clog2(MAX_PERIOD);
   localparam beat_t LAST_BEAT = beat_t'(NUM_BEATS - 1);

   beat_state_t      state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] period_last;
   beat_t            beat_next;
   logic             beat_strobe_next, bar_strobe_next;
   tempo_idx_t       tempo_idx_q;

   tempo_ctrl #(
      .MAX_PERIOD    (MAX_PERIOD),
      .STEP_PERIOD   (STEP_PERIOD),
      .DEFAULT_TEMPO (DEFAULT_TEMPO),
      .CNT_W         (CNT_W)
   ) u_tempo_ctrl (
      .clk         (clk),
      .rst         (rst),
      .tempo_up    (tempo_up),
      .tempo_down  (tempo_down),
      .tempo_idx   (tempo_idx_q),
      .period_last (period_last)
   );

   assign tempo_idx = tempo_idx_q;

   // NOTE: every variable gets a default before the case so that no path
   // leaves it unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      beat_next        = beat;
      beat_strobe_next = 1'b0;
      bar_strobe_next  = 1'b0;

      if (!sequencer_on) begin
         state_next = IDLE;
         cnt_next   = '0;
         beat_next  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_next  = '0;
               beat_next = '0;
               if (pause) begin
                  state_next = PAUSE;
               end else begin
                  state_next       = RUN;
                  beat_strobe_next = 1'b1;
                  bar_strobe_next  = 1'b1;
               end
            end
            RUN: begin
               if (pause) begin
                  state_next = PAUSE;
               end else if (cnt >= period_last) begin
                  // >= so a tempo raise mid-beat ends the beat at once
                  // instead of wrapping the counter.
                  cnt_next         = '0;
                  beat_next        = beat + beat_t'(1);
                  beat_strobe_next = 1'b1;
                  bar_strobe_next  = (beat == LAST_BEAT);
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            PAUSE: begin
               if (!pause) state_next = RUN;
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               beat_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         beat        <= '0;
         beat_strobe <= 1'b0;
         bar_strobe  <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         beat        <= beat_next;
         beat_strobe <= beat_strobe_next;
         bar_strobe  <= bar_strobe_next;
      end
   end

endmodule
